pes_demux: RTL and testbench

- Parametrised successor to the program-stream splitter. Parses an MPEG-1 or MPEG-2 program stream byte-wise, identifies PES packets, strips PES headers, and routes payload bytes to one of NUM_CH channel FIFOs by programmable stream_id match.
- All non-routed bytes (pack headers, system headers, unmatched packets, PES headers) go to a misc FIFO.
- Sits between the stream input FIFO and the per-elementary-stream decoder FIFOs.

---
 rtl/pes_demux.sv | 224 ++++++++++++++++++++++
 tb/tb_pes_demux.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pes_demux.sv
`default_nettype none
// ============================================================================
// Module   : pes_demux
// Purpose  : Byte-wise MPEG-1/MPEG-2 program-stream parser. Detects PES
//            packets, strips their headers and steers payload bytes to one of
//            NUM_CH channel FIFOs by masked stream_id match. Everything else
//            (pack/system headers, PES headers, unmatched packets) is written
//            to the misc FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pes_demux #(
  parameter int NUM_CH   = 2,
  parameter int MPEG2_EN = 1,
  parameter int MISC_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [7:0]          stream_in,
  input  logic                stream_empty,
  input  logic                stream_end_in,
  output logic                stream_rd,
  input  logic [8*NUM_CH-1:0] ch_id,
  input  logic [8*NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0]   ch_afull,
  input  logic                misc_afull,
  output logic [7:0]          stream_out,
  output logic [NUM_CH-1:0]   ch_wr,
  output logic                misc_wr,
  output logic                stream_end_out,
  output logic                hdr_err
);

  localparam int                CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] CH_ONE   = NUM_CH'(1);
  localparam logic              MISC_ON  = (MISC_EN != 0);
  localparam logic              MPEG2_ON = (MPEG2_EN != 0);

  typedef enum logic [3:0] {
    S_SYNC    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_HDR1    = 4'd3,
    S_STD     = 4'd4,
    S_H2F     = 4'd5,
    S_H2LEN   = 4'd6,
    S_TS      = 4'd7,
    S_SKIP    = 4'd8,
    S_PAYLOAD = 4'd9
  } state_t;

  state_t            state;
  logic              held;       // a byte from the input FIFO is on stream_in
  logic [23:0]       sr;         // start-code shift register (SYNC only)
  logic [15:0]       cnt;        // bytes remaining in the current PES packet
  logic [7:0]        len_hi;     // upper length byte, waiting for the lower
  logic [7:0]        sub_cnt;    // timestamp / header-skip byte counter
  logic              ch_valid;   // current packet is routed to a channel
  logic [CH_W-1:0]   ch_sel;     // channel latched at packet start

  logic              stall;
  logic              adv;
  logic              take;
  logic              hit;
  logic [CH_W-1:0]   hit_idx;
  logic              pkt_start;
  logic              last;
  logic              in_hdr;
  logic              hdr1_ok;
  logic              err;
  logic              to_ch;

  // Input handshake: a held byte is consumed whenever no downstream FIFO is near full
  always_comb begin
    stall     = (|ch_afull) | (misc_afull & MISC_ON);
    adv       = held & ~stall;
    stream_rd = clk_en & (~held | adv);
    take      = clk_en & adv;
  end

  // Lowest-numbered channel whose masked stream_id equals the current byte
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (((stream_in ^ ch_id[8*k +: 8]) & ch_mask[8*k +: 8]) == 8'h00) begin
        hit     = 1'b1;
        hit_idx = CH_W'(k);
      end
    end
  end

  // Per-byte classification of the byte currently on stream_in
  always_comb begin
    pkt_start = (state == S_SYNC) && (sr == 24'h000001) && (stream_in >= 8'hBD);
    last      = (cnt == 16'd1);
    in_hdr    = (state == S_HDR1) || (state == S_STD) || (state == S_H2F) ||
                (state == S_H2LEN) || (state == S_TS) || (state == S_SKIP);
    hdr1_ok   = (stream_in == 8'hFF) ||
                (stream_in[7:6] == 2'b01) ||
                ((stream_in[7:6] == 2'b10) && MPEG2_ON) ||
                (stream_in[7:4] == 4'b0010) ||
                (stream_in[7:4] == 4'b0011) ||
                (stream_in == 8'h0F);
    // Running out of packet inside the header is as malformed as a bad marker byte
    err       = in_hdr && (last || ((state == S_HDR1) && !hdr1_ok));
    to_ch     = (state == S_PAYLOAD) && ch_valid;
  end

  // Held-byte flag, output byte register and write/error strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      held           <= 1'b0;
      stream_out     <= 8'h00;
      ch_wr          <= '0;
      misc_wr        <= 1'b0;
      hdr_err        <= 1'b0;
      stream_end_out <= 1'b0;
    end else begin
      ch_wr   <= '0;
      misc_wr <= 1'b0;
      hdr_err <= 1'b0;
      if (clk_en) begin
        held           <= (held & ~adv) | (stream_rd & ~stream_empty);
        stream_end_out <= stream_end_in & stream_empty & ~held;
      end
      if (take) begin
        stream_out <= stream_in;
        hdr_err    <= err;
        if (to_ch) begin
          ch_wr <= CH_ONE << ch_sel;
        end else begin
          misc_wr <= MISC_ON;
        end
      end
    end
  end

  // Packet parser: advances one step per consumed byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_SYNC;
      sr       <= 24'hFFFFFF;
      cnt      <= 16'd0;
      len_hi   <= 8'h00;
      sub_cnt  <= 8'h00;
      ch_valid <= 1'b0;
      ch_sel   <= '0;
    end else if (take) begin
      case (state)
        S_SYNC: begin
          sr <= {sr[15:0], stream_in};
          if (pkt_start) begin
            // Clear the start code so the stream_id byte can never re-trigger
            sr       <= 24'hFFFFFF;
            state    <= S_LEN_HI;
            ch_valid <= hit && (stream_in != 8'hBE) && (stream_in != 8'hBF);
            ch_sel   <= hit_idx;
          end
        end
        S_LEN_HI: begin
          len_hi <= stream_in;
          state  <= S_LEN_LO;
        end
        S_LEN_LO: begin
          cnt <= {len_hi, stream_in};
          if ({len_hi, stream_in} == 16'd0) begin
            state <= S_SYNC;
          end else if (ch_valid) begin
            state <= S_HDR1;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        default: begin
          cnt <= cnt - 16'd1;
          if (err) begin
            state <= S_SYNC;
          end else begin
            case (state)
              S_HDR1: begin
                if (stream_in == 8'hFF) begin
                  state <= S_HDR1;
                end else if (stream_in[7:6] == 2'b01) begin
                  state <= S_STD;
                end else if (stream_in[7:6] == 2'b10) begin
                  state <= S_H2F;
                end else if (stream_in[7:4] == 4'b0010) begin
                  state   <= S_TS;
                  sub_cnt <= 8'd4;
                end else if (stream_in[7:4] == 4'b0011) begin
                  state   <= S_TS;
                  sub_cnt <= 8'd9;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
              S_STD:   state <= S_HDR1;
              S_H2F:   state <= S_H2LEN;
              S_H2LEN: begin
                sub_cnt <= stream_in;
                state   <= (stream_in == 8'h00) ? S_PAYLOAD : S_SKIP;
              end
              S_TS, S_SKIP: begin
                sub_cnt <= sub_cnt - 8'd1;
                if (sub_cnt == 8'd1) begin
                  state <= S_PAYLOAD;
                end
              end
              S_PAYLOAD: begin
                if (last) begin
                  state <= S_SYNC;
                end
              end
              default: state <= S_SYNC;
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pes_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pes_demux
// Purpose  : Scoreboard bench for pes_demux. Program streams are built from
//            packet descriptions; each byte's expected destination is derived
//            from the packet layout and pushed to a queue that a monitor
//            drains as write strobes appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pes_demux;

  localparam int NUM_CH    = 2;
  localparam int MISC_DEST = NUM_CH;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] dest;
    logic       err;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                clk_en;
  logic [7:0]          stream_in;
  logic                stream_empty;
  logic                stream_end_in;
  logic                stream_rd;
  logic [8*NUM_CH-1:0] ch_id;
  logic [8*NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0]   ch_afull;
  logic                misc_afull;
  logic [7:0]          stream_out;
  logic [NUM_CH-1:0]   ch_wr;
  logic                misc_wr;
  logic                stream_end_out;
  logic                hdr_err;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] in_q[$];
  exp_t       exp_q[$];
  logic [7:0] hq[$];
  logic [7:0] pq[$];

  bit fire        = 1'b0;
  bit mon_en      = 1'b0;
  bit hold_empty  = 1'b1;
  bit force_af0   = 1'b0;
  int gap_pct     = 0;
  int stall_pct   = 0;
  int ce_low_pct  = 0;

  pes_demux #(.NUM_CH(NUM_CH), .MPEG2_EN(1), .MISC_EN(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .stream_in      (stream_in),
    .stream_empty   (stream_empty),
    .stream_end_in  (stream_end_in),
    .stream_rd      (stream_rd),
    .ch_id          (ch_id),
    .ch_mask        (ch_mask),
    .ch_afull       (ch_afull),
    .misc_afull     (misc_afull),
    .stream_out     (stream_out),
    .ch_wr          (ch_wr),
    .misc_wr        (misc_wr),
    .stream_end_out (stream_end_out),
    .hdr_err        (hdr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic int match_ch(input logic [7:0] id);
    for (int k = 0; k < NUM_CH; k++) begin
      if (((id ^ ch_id[8*k +: 8]) & ch_mask[8*k +: 8]) == 8'h00) return k;
    end
    return -1;
  endfunction

  task automatic push_byte(input logic [7:0] d, input int dest, input bit err);
    exp_t e;
    e.data = d;
    e.dest = 4'(dest);
    e.err  = err;
    in_q.push_back(d);
    exp_q.push_back(e);
  endtask

  // Non-zero filler can never complete a 00 00 01 start code
  task automatic push_filler(input int n);
    for (int i = 0; i < n; i++) push_byte(8'($urandom_range(2, 255)), MISC_DEST, 1'b0);
  endtask

  task automatic push_pack_hdr();
    push_byte(8'h00, MISC_DEST, 1'b0);
    push_byte(8'h00, MISC_DEST, 1'b0);
    push_byte(8'h01, MISC_DEST, 1'b0);
    push_byte(8'hBA, MISC_DEST, 1'b0);
    push_filler(3);
  endtask

  task automatic gen_pay(input int n, input bit nonzero);
    pq.delete();
    for (int i = 0; i < n; i++)
      pq.push_back(nonzero ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 255)));
  endtask

  // Random well-formed PES header (MPEG-1 or MPEG-2 style)
  task automatic gen_hdr();
    int n;
    hq.delete();
    case ($urandom_range(0, 4))
      0: hq.push_back(8'h0F);
      1: begin
        hq.push_back(8'h20 | 8'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) hq.push_back(8'($urandom_range(0, 255)));
      end
      2: begin
        hq.push_back(8'h30 | 8'($urandom_range(0, 15)));
        for (int i = 0; i < 9; i++) hq.push_back(8'($urandom_range(0, 255)));
      end
      3: begin
        n = $urandom_range(0, 5);
        hq.push_back(8'h80 | 8'($urandom_range(0, 63)));
        hq.push_back(8'($urandom_range(0, 255)));
        hq.push_back(8'(n));
        for (int i = 0; i < n; i++) hq.push_back(8'($urandom_range(0, 255)));
      end
      default: begin
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) hq.push_back(8'hFF);
        hq.push_back(8'h40 | 8'($urandom_range(0, 63)));
        hq.push_back(8'($urandom_range(0, 255)));
        hq.push_back(8'h0F);
      end
    endcase
  endtask

  // One PES packet from hq (header) and pq (payload); len_ovr >= 0 truncates
  task automatic push_pkt(input logic [7:0] id, input bit bad, input int len_ovr);
    logic [7:0] body[$];
    int  len;
    int  k;
    bit  routed;
    body.delete();
    foreach (hq[i]) body.push_back(hq[i]);
    foreach (pq[i]) body.push_back(pq[i]);
    len = (len_ovr >= 0) ? len_ovr : body.size();
    push_byte(8'h00, MISC_DEST, 1'b0);
    push_byte(8'h00, MISC_DEST, 1'b0);
    push_byte(8'h01, MISC_DEST, 1'b0);
    push_byte(id, MISC_DEST, 1'b0);
    push_byte(8'(len >> 8), MISC_DEST, 1'b0);
    push_byte(8'(len), MISC_DEST, 1'b0);
    k = match_ch(id);
    routed = (k >= 0) && (id != 8'hBE) && (id != 8'hBF);
    for (int i = 0; i < len; i++) begin
      if (!routed)                 push_byte(body[i], MISC_DEST, 1'b0);
      else if (bad)                push_byte(body[i], MISC_DEST, i == 0);
      else if (len <= hq.size())   push_byte(body[i], MISC_DEST, i == len - 1);
      else if (i < hq.size())      push_byte(body[i], MISC_DEST, 1'b0);
      else                         push_byte(body[i], k, 1'b0);
    end
  endtask

  task automatic rand_pkt();
    logic [7:0] ids[7];
    logic [7:0] id;
    int r;
    ids = '{8'hE0, 8'hE5, 8'hC0, 8'hC3, 8'hBD, 8'hBE, 8'hBF};
    id = ids[$urandom_range(0, 6)];
    r = $urandom_range(0, 9);
    if ($urandom_range(0, 3) == 0) push_pack_hdr();
    push_filler($urandom_range(0, 4));
    if (r == 0) begin
      hq.delete();
      hq.push_back(($urandom_range(0, 1) == 0) ? 8'hC5 : 8'hF0);
      gen_pay($urandom_range(0, 4), 1'b1);
      push_pkt(id, 1'b1, -1);
    end else if (r == 1) begin
      gen_hdr();
      gen_pay(2, 1'b0);
      push_pkt(id, 1'b0, $urandom_range(1, hq.size()));
    end else if (r == 2) begin
      hq.delete();
      pq.delete();
      push_pkt(id, 1'b0, -1);
    end else begin
      gen_hdr();
      gen_pay($urandom_range(1, 12), 1'b0);
      push_pkt(id, 1'b0, -1);
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, name, exp_q.size(), 0);
  endtask

  // Input FIFO model and downstream back-pressure
  initial begin
    stream_in    = 8'h00;
    stream_empty = 1'b1;
    ch_afull     = '0;
    misc_afull   = 1'b0;
    clk_en       = 1'b1;
    forever begin
      @(negedge clk);
      if (fire && in_q.size() > 0) stream_in = in_q.pop_front();
      stream_empty = hold_empty || (in_q.size() == 0) ||
                     (int'($urandom_range(0, 99)) < gap_pct);
      ch_afull     = (int'($urandom_range(0, 99)) < stall_pct) ?
                     NUM_CH'($urandom_range(0, 3)) : '0;
      ch_afull[0]  = ch_afull[0] | force_af0;
      misc_afull   = (int'($urandom_range(0, 99)) < stall_pct) ? 1'b1 : 1'b0;
      clk_en       = (int'($urandom_range(0, 99)) >= ce_low_pct);
      #1;
      fire = stream_rd && !stream_empty;
    end
  end

  // Monitor: every write strobe must match the next expected byte
  always @(negedge clk) begin
    if (mon_en) begin
      if (ch_wr != '0 || misc_wr) begin
        int   d;
        exp_t e;
        d = 15;
        if (misc_wr && ch_wr == '0) d = MISC_DEST;
        else if (!misc_wr && $onehot(ch_wr)) begin
          for (int k = 0; k < NUM_CH; k++) if (ch_wr[k]) d = k;
        end
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", int'(stream_out), 0);
        end else begin
          e = exp_q.pop_front();
          chk(stream_out == e.data, "data", int'(stream_out), int'(e.data));
          chk(d == int'(e.dest), "dest", d, int'(e.dest));
          chk(hdr_err == e.err, "hdr_err", int'(hdr_err), int'(e.err));
        end
      end else if (hdr_err) begin
        chk(1'b0, "hdr_err_without_write", 1, 0);
      end
    end
  end

  initial begin
    int t;
    rst           = 1'b1;
    stream_end_in = 1'b0;
    ch_id         = {8'hC0, 8'hE0};
    ch_mask       = {8'hE0, 8'hFF};
    repeat (3) @(negedge clk);
    chk(ch_wr == '0, "reset_ch_wr", int'(ch_wr), 0);
    chk(misc_wr == 1'b0, "reset_misc_wr", int'(misc_wr), 0);
    chk(stream_out == 8'h00, "reset_stream_out", int'(stream_out), 0);
    chk(hdr_err == 1'b0, "reset_hdr_err", int'(hdr_err), 0);
    chk(stream_end_out == 1'b0, "reset_end_out", int'(stream_end_out), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    hold_empty = 1'b0;

    // Directed packets from the reference scenarios
    push_filler(3);
    hq = '{8'h21, 8'h11, 8'h22, 8'h33, 8'h44};
    pq = '{8'hAA, 8'hBB, 8'hCC};
    push_pkt(8'hE0, 1'b0, -1);
    hq = '{8'h81, 8'h80, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    pq = '{8'h55};
    push_pkt(8'hC0, 1'b0, -1);
    hq.delete();
    pq = '{8'h10, 8'h20, 8'h30};
    push_pkt(8'hE5, 1'b0, -1);
    hq = '{8'h31, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    pq.delete();
    push_pkt(8'hE0, 1'b0, 2);
    hq = '{8'h0F};
    pq = '{8'h00, 8'h00, 8'h01, 8'hE0};
    push_pkt(8'hE0, 1'b0, -1);
    hq = '{8'hC5};
    pq = '{8'h12, 8'h34};
    push_pkt(8'hC5, 1'b1, -1);
    push_filler(2);
    wait_drain("drain_directed");

    // Randomised traffic with back-pressure, input gaps and clock-enable holes
    gap_pct = 20;
    stall_pct = 10;
    ce_low_pct = 10;
    for (int i = 0; i < 30; i++) rand_pkt();
    hq = '{8'h0F};
    gen_pay(40, 1'b0);
    push_pkt(8'hE0, 1'b0, -1);
    for (int i = 0; i < 10; i++) rand_pkt();
    t = 0;
    while (exp_q.size() > 300 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    force_af0 = 1'b1;
    repeat (4) @(negedge clk);
    force_af0 = 1'b0;
    wait_drain("drain_random");

    // BD..BF now match channel 1; BE/BF must still bypass header parsing
    ch_id   = {8'hB0, 8'hE0};
    ch_mask = {8'hF0, 8'hFF};
    for (int i = 0; i < 25; i++) rand_pkt();
    wait_drain("drain_bx");

    // Reset in the middle of a long payload
    hq = '{8'h0F};
    gen_pay(60, 1'b0);
    push_pkt(8'hBD, 1'b0, -1);
    t = 0;
    while (exp_q.size() > 30 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    mon_en = 1'b0;
    hold_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(ch_wr == '0 && misc_wr == 1'b0, "reset_drops_strobes", int'({ch_wr, misc_wr}), 0);
    @(negedge clk);
    in_q.delete();
    exp_q.delete();
    rst = 1'b0;
    mon_en = 1'b1;
    hold_empty = 1'b0;
    for (int i = 0; i < 10; i++) rand_pkt();
    hq = '{8'h21, 8'h01, 8'h02, 8'h03, 8'h04};
    pq = '{8'h77, 8'h88};
    push_pkt(8'hBD, 1'b0, -1);

    // End of stream once everything is drained
    gap_pct = 0;
    stall_pct = 0;
    ce_low_pct = 0;
    wait_drain("drain_final");
    chk(stream_end_out == 1'b0, "end_out_before_end", int'(stream_end_out), 0);
    stream_end_in = 1'b1;
    t = 0;
    while (!stream_end_out && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(stream_end_out == 1'b1, "end_out", int'(stream_end_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
